// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// The NIBBLE_SUB_EN build option is handled in the interface and top files.
package nibble_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SLICE_W = 4;

    // Counter width for NSLICE steps; never narrower than one bit.
    function automatic int cnt_width(input int nslice);
        return (nslice <= 2) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Start/result handshake bundle for nibble_serial_add_ctrl.
// The sub input exists only when NIBBLE_SUB_EN is defined.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    // Both channels are valid/ready: a transfer happens on a rising clk edge
    // where valid and ready are both high. The start side samples op_a, op_b,
    // carryin (and sub) on that edge; the result side holds sum and carryout
    // stable while out_valid is high and out_ready is low.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carryin;
`ifdef NIBBLE_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, carryin, out_ready,
`ifdef NIBBLE_SUB_EN
        output sub,
`endif
        input  in_ready, out_valid, sum, carryout, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, carryin, out_ready,
`ifdef NIBBLE_SUB_EN
        input  sub,
`endif
        output in_ready, out_valid, sum, carryout, busy
    );

endinterface

// File: rtl/nibble_serial_add_ctrl_slice.sv
// Combinational 4-bit ripple adder slice shared by every nibble step.
module nibble_slice_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder: one 4-bit slice, LSB nibble first, carry held
// between steps. Define NIBBLE_SUB_EN to add the sub input (A - B - carryin).
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    nibble_serial_add_ctrl_if.slave  bus,
    output state_e                   state_o
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = cnt_width(NSLICE);

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
    logic               sub_eff;

`ifdef NIBBLE_SUB_EN
    assign sub_eff = bus.sub;
`else
    assign sub_eff = 1'b0;
`endif

    nibble_slice_add u_slice (
        .a  (a_q[SLICE_W-1:0]),
        .b  (b_q[SLICE_W-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction is A + ~B + ~carryin, so the no-borrow flag
                    // falls out as the final carry.
                    a_d     = bus.op_a;
                    b_d     = sub_eff ? ~bus.op_b : bus.op_b;
                    carry_d = bus.carryin ^ sub_eff;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = (sum_q >> SLICE_W) | (WIDTH'(slice_s) << (WIDTH - SLICE_W));
                a_d     = a_q >> SLICE_W;
                b_d     = b_q >> SLICE_W;
                carry_d = slice_co;
                // The counter parks at NSLICE-1 and is only cleared on the next capture.
                if (cnt_q == CNT_W'(NSLICE - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.carryout  = carry_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl (WIDTH=16 and WIDTH=4).
// Subtract vectors are included when NIBBLE_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;
    import nibble_add_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [16:0] exp_q[$];

    state_e state16;
    state_e state4;

    nibble_serial_add_ctrl_if #(.WIDTH(16)) bus16 ();
    nibble_serial_add_ctrl_if #(.WIDTH(4))  bus4 ();

    nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus16),
        .state_o (state16)
    );

    nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus4),
        .state_o (state4)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic wait_valid16(input string tag, input int exp_lat);
        int cycles;
        cycles = 0;
        while (bus16.out_valid !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
    endtask

    task automatic compare_result16(input string tag);
        logic [16:0] exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1_FFFF;
        check({tag, "_result"}, {15'd0, bus16.carryout, bus16.sum}, {15'd0, exp});
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sb, input logic [15:0] exp_sum, input logic exp_c,
                         input string tag);
        bus16.in_valid = 1'b1;
        bus16.op_a     = a;
        bus16.op_b     = b;
        bus16.carryin  = cin;
`ifdef NIBBLE_SUB_EN
        bus16.sub      = sb;
`endif
        check({tag, "_in_ready"}, 32'(bus16.in_ready), 32'd1);
        exp_q.push_back({exp_c, exp_sum});
        @(negedge clk);
        bus16.in_valid = 1'b0;
        bus16.op_a     = ~a;
        bus16.op_b     = ~b;
        bus16.carryin  = ~cin;
`ifdef NIBBLE_SUB_EN
        bus16.sub      = ~sb;
`endif
        check({tag, "_run_busy"}, {30'd0, bus16.busy, bus16.in_ready}, 32'b10);
        wait_valid16(tag, 4);
        compare_result16(tag);
        bus16.out_ready = 1'b1;
        @(negedge clk);
        bus16.out_ready = 1'b0;
        check({tag, "_back_idle"}, {30'd0, bus16.out_valid, bus16.in_ready}, 32'b01);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cycles;
        logic saw_valid;

        bus16.in_valid = 1'b0; bus16.op_a = '0; bus16.op_b = '0;
        bus16.carryin = 1'b0; bus16.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.op_a = '0; bus4.op_b = '0;
        bus4.carryin = 1'b0; bus4.out_ready = 1'b0;
`ifdef NIBBLE_SUB_EN
        bus16.sub = 1'b0;
        bus4.sub  = 1'b0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(bus16.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        check("rst_busy",      32'(bus16.busy),      32'd0);
        check("rst_sum",       32'(bus16.sum),       32'd0);
        check("rst_carryout",  32'(bus16.carryout),  32'd0);
        check("rst_state",     32'(state16),         32'(IDLE));
        rst = 1'b0;

        // out_ready with no result pending
        bus16.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_out_ready", {30'd0, bus16.out_valid, bus16.in_ready}, 32'b01);
        bus16.out_ready = 1'b0;

        // Basic vectors
        run16(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, "add_1234");
        run16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, "ripple_ffff");
        run16(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, "msb_carry");
        run16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, "max_sum");
        run16(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, "mid_carry");

        // Backpressure: result held, start held off until a cycle after out_ready
        bus16.in_valid = 1'b1; bus16.op_a = 16'h00F0; bus16.op_b = 16'h0010; bus16.carryin = 1'b0;
        exp_q.push_back({1'b0, 16'h0100});
        @(negedge clk);
        bus16.op_a = 16'h0002; bus16.op_b = 16'h0003;
        wait_valid16("bp", 4);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {14'd0, bus16.in_ready, bus16.out_valid, bus16.carryout, bus16.sum},
                  {14'd0, 1'b0, 1'b1, 1'b0, 16'h0100});
            @(negedge clk);
        end
        compare_result16("bp");
        bus16.out_ready = 1'b1;
        @(negedge clk);
        bus16.out_ready = 1'b0;
        check("bp_no_bypass", {30'd0, bus16.busy, bus16.in_ready}, 32'b01);
        exp_q.push_back({1'b0, 16'h0005});
        @(negedge clk);
        bus16.in_valid = 1'b0;
        check("bp_second_accept", 32'(bus16.busy), 32'd1);
        wait_valid16("bp2", 4);
        compare_result16("bp2");
        bus16.out_ready = 1'b1;
        @(negedge clk);
        bus16.out_ready = 1'b0;

        // Reset in the middle of a run
        bus16.in_valid = 1'b1; bus16.op_a = 16'hAAAA; bus16.op_b = 16'h5555; bus16.carryin = 1'b0;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_outputs",
              {13'd0, bus16.in_ready, bus16.out_valid, bus16.busy, bus16.carryout, bus16.sum},
              {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        check("midrst_state", 32'(state16), 32'(IDLE));
        saw_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_valid = saw_valid | bus16.out_valid;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_valid = saw_valid | bus16.out_valid;
        end
        check("midrst_no_valid", 32'(saw_valid), 32'd0);
        run16(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, "after_rst");

`ifdef NIBBLE_SUB_EN
        run16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, "sub_borrow");
        run16(16'h0009, 16'h0003, 1'b0, 1'b1, 16'h0006, 1'b1, "sub_noborrow");
        run16(16'h0009, 16'h0003, 1'b0, 1'b0, 16'h000C, 1'b0, "sub0_add");
`endif

        // WIDTH=4: single nibble step
        bus4.in_valid = 1'b1; bus4.op_a = 4'h9; bus4.op_b = 4'h8; bus4.carryin = 1'b1;
        check("w4_in_ready", 32'(bus4.in_ready), 32'd1);
        @(negedge clk);
        bus4.in_valid = 1'b0; bus4.op_a = 4'h0; bus4.op_b = 4'h0; bus4.carryin = 1'b0;
        cycles = 0;
        while (bus4.out_valid !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check("w4_latency", 32'(cycles), 32'd1);
        check("w4_result", {27'd0, bus4.carryout, bus4.sum}, {27'd0, 1'b1, 4'h2});
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        check("w4_back_idle", {30'd0, bus4.out_valid, bus4.in_ready}, 32'b01);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that computes a WIDTH-bit sum over successive clock cycles using one shared 4-bit ripple adder slice.
- Uses one nibble per cycle, least-significant first, with the carry held in a register between cycles.
- Sits between a requester, through a valid/ready start handshake, and a consumer, through a valid/ready result handshake.
- Trades latency for area in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NSLICE, WIDTH/4, derived; number of nibble steps; not user-overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  requester presents operands.
- in_ready  out  1  block can accept operands.
- op_a  in  WIDTH  addend A, sampled on the in handshake.
- op_b  in  WIDTH  addend B, sampled on the in handshake.
- carryin  in  1  initial carry, sampled on the in handshake.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- carryout  out  1  final carry.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync deassert handled externally) forces:
  - FSM=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carryout=0.
  - Slice counter=0, carry register=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture op_a, op_b into shift registers and carryin into the carry register; clear the counter; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, feed the low nibbles of the A/B shift registers plus the carry register to the slice adder.
  - Shift the slice sum into the MSB nibble of the sum register (sum shifts right 4).
  - Shift the A/B registers right by 4 and update the carry register with the slice carry.
  - Increment the counter.
  - When the counter reaches NSLICE-1 this cycle, go to DONE.
- DONE:
  - out_valid=1; sum and carryout hold stable while out_valid=1 and out_ready=0.
  - carryout is the carry register.
  - On out_valid&out_ready go to IDLE.
  - Next start accepted no earlier than the following cycle, so there is no same-cycle bypass.
- Latency: handshake at edge 0 gives out_valid high after edge NSLICE (16-bit: 4 cycles).
- Throughput: one operation per NSLICE+2 cycles minimum.
- Arithmetic: sum = (op_a + op_b + carryin) mod 2^WIDTH; carryout = bit WIDTH of the full sum.
- Boundary conditions:
  - in_valid while not in IDLE is ignored; it is held off by in_ready=0.
  - Operands changing after capture have no effect.
  - The counter wraps only through return to IDLE, never mid-run.
  - rst mid-RUN or mid-DONE aborts immediately to reset values; the partial result is discarded and out_valid does not pulse.
  - out_ready held high with no result has no effect.
  - The sum register is visible during RUN but is only valid when out_valid=1.

Optional Feature:
- Macro: NIBBLE_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on the in handshake.
  - When sub=1, the block stores ~op_b and uses ~carryin as the initial carry, giving sum = op_a - op_b - carryin mod 2^WIDTH.
  - carryout then means no-borrow: 1 when op_a >= op_b + carryin.
  - When sub=0, behaviour is identical to add mode.
- Not defined: port absent, add only.
- Latency identical in both cases.

Decomposition:
- Shared package nibble_add_pkg:
  - state enum {IDLE, RUN, DONE}.
  - localparam SLICE_W=4.
  - function computing counter width, clog2 of NSLICE with minimum 1.
- Sub-module nibble_slice_add:
  - Purely combinational 4-bit adder with inputs a[3:0], b[3:0], ci and outputs s[3:0], co.
  - Instantiated once in the controller.

Test Plan:
- WIDTH=16: A=0x1234, B=0x4321, cin=0 -> after 4 cycles out_valid=1, sum=0x5555, carryout=0.
- WIDTH=16: A=0xFFFF, B=0x0000, cin=1 -> sum=0x0000, carryout=1; checks full carry ripple across all four nibbles.
- Backpressure: out_ready=0 for 5 cycles after a result of A=0x00F0, B=0x0010 -> sum=0x0100 held stable, in_ready=0 throughout, and a second in_valid is not accepted until a cycle after out_ready=1.
- Reset mid-RUN: assert rst in cycle 2 of A=0xAAAA, B=0x5555 -> outputs return to reset values the same cycle, out_valid never asserts; a subsequent A=0x0001, B=0x0001 gives 0x0002.
- NIBBLE_SUB_EN with sub=1: A=0x0005, B=0x0007, cin=0 -> sum=0xFFFE, carryout=0; A=0x0009, B=0x0003 -> sum=0x0006, carryout=1.
- WIDTH=4 edge: A=0x9, B=0x8, cin=1 -> out_valid after 1 cycle, sum=0x2, carryout=1.
